// File: rtl/axil_default_slave.sv
// AXI-Lite default slave: answers every transaction that decodes to no window with DECERR.
// Latency: B one cycle after the last of AW/W handshakes, R one cycle after the AR handshake.
// Backpressure: one outstanding transaction per channel; readys drop until bready/rready drain the response.
//
// Ports (AXI-Lite slave side, all synchronous to aclk):
//   aclk, areset                  clock and synchronous active-high reset
//   s_aw*/s_w*/s_b*               write address / data / response channels
//   s_ar*/s_r*                    read address / data channels
//   err_addr, err_is_wr, err_cnt  decode-error log, present only when AXIL_DECERR_LOG_EN is defined
//
// The write and read FSMs are independent. Every output is decoded from state flops only,
// so there is no combinational path from any input to any output.
module axil_default_slave #(
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter logic [31:0] RDATA_FILL     = 32'hDEAD_BEEF
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_awaddr,
  input  logic                        s_awvalid,
  output logic                        s_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                        s_wvalid,
  output logic                        s_wready,
  output logic [1:0]                  s_bresp,
  output logic                        s_bvalid,
  input  logic                        s_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_araddr,
  input  logic                        s_arvalid,
  output logic                        s_arready,
  output logic [AXI_DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]                  s_rresp,
  output logic                        s_rvalid,
  input  logic                        s_rready
`ifdef AXIL_DECERR_LOG_EN
  ,
  output logic [AXI_ADDR_WIDTH-1:0]   err_addr,
  output logic                        err_is_wr,
  output logic [15:0]                 err_cnt
`endif
);

  localparam logic [1:0]                RESP_DECERR = 2'b11;
  localparam logic [1:0]                RESP_OKAY   = 2'b00;
  localparam logic [AXI_DATA_WIDTH-1:0] FILL        = AXI_DATA_WIDTH'(RDATA_FILL);

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_WAIT_W  = 2'd1,
    W_WAIT_AW = 2'd2,
    W_RESP    = 2'd3
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;

  logic aw_hs;
  logic w_hs;
  logic ar_hs;

  // Payloads are never stored; the addresses matter only to the optional log.
  logic unused_payload;
  assign unused_payload = ^{s_wdata, s_wstrb, s_awaddr, s_araddr};

  // ---------------- write channel ----------------
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_state_q <= W_IDLE;
    end else begin
      wr_state_q <= wr_state_d;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    s_awready  = 1'b0;
    s_wready   = 1'b0;
    s_bvalid   = 1'b0;
    s_bresp    = RESP_OKAY;
    unique case (wr_state_q)
      W_IDLE: begin
        s_awready = 1'b1;
        s_wready  = 1'b1;
        if (s_awvalid && s_wvalid) begin
          wr_state_d = W_RESP;
        end else if (s_awvalid) begin
          wr_state_d = W_WAIT_W;
        end else if (s_wvalid) begin
          wr_state_d = W_WAIT_AW;
        end
      end
      W_WAIT_W: begin
        s_wready = 1'b1;
        if (s_wvalid) begin
          wr_state_d = W_RESP;
        end
      end
      W_WAIT_AW: begin
        s_awready = 1'b1;
        if (s_awvalid) begin
          wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        s_bvalid = 1'b1;
        s_bresp  = RESP_DECERR;
        // Returning to IDLE for at least one cycle gives the one-bubble minimum between bursts.
        if (s_bready) begin
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  assign aw_hs = s_awvalid && s_awready;
  assign w_hs  = s_wvalid && s_wready;

  // ---------------- read channel ----------------
  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_state_q <= R_IDLE;
    end else begin
      rd_state_q <= rd_state_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    s_arready  = 1'b0;
    s_rvalid   = 1'b0;
    s_rresp    = RESP_OKAY;
    s_rdata    = '0;
    unique case (rd_state_q)
      R_IDLE: begin
        s_arready = 1'b1;
        if (s_arvalid) begin
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        s_rvalid = 1'b1;
        s_rresp  = RESP_DECERR;
        s_rdata  = FILL;
        if (s_rready) begin
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  assign ar_hs = s_arvalid && s_arready;

  logic unused_hs;
  assign unused_hs = w_hs;

`ifdef AXIL_DECERR_LOG_EN
  // ---------------- decode-error log ----------------
  logic [AXI_ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic                      err_is_wr_q, err_is_wr_d;
  logic [15:0]               err_cnt_q, err_cnt_d;
  logic [16:0]               cnt_sum;

  always_comb begin
    err_addr_d  = err_addr_q;
    err_is_wr_d = err_is_wr_q;
    // A same-cycle AW overrides AR so the logged address is the write.
    if (aw_hs) begin
      err_addr_d  = s_awaddr;
      err_is_wr_d = 1'b1;
    end else if (ar_hs) begin
      err_addr_d  = s_araddr;
      err_is_wr_d = 1'b0;
    end
    // 17-bit sum exposes the carry used for saturation.
    cnt_sum   = {1'b0, err_cnt_q} + {16'd0, aw_hs} + {16'd0, ar_hs};
    err_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      err_addr_q  <= '0;
      err_is_wr_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      err_addr_q  <= err_addr_d;
      err_is_wr_q <= err_is_wr_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign err_addr  = err_addr_q;
  assign err_is_wr = err_is_wr_q;
  assign err_cnt   = err_cnt_q;
`else
  logic unused_log;
  assign unused_log = aw_hs ^ ar_hs;
`endif

endmodule

// File: tb/tb_axil_default_slave.sv
// Directed bench for axil_default_slave: hand-computed DECERR responses and handshake timing.
// Inputs change 1 ns after the rising edge; outputs are checked there too, so they reflect the new state.
// With AXIL_DECERR_LOG_EN defined the log ports are connected and checked as well.
module tb_axil_default_slave;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] s_awaddr;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic [31:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;
`ifdef AXIL_DECERR_LOG_EN
  logic [31:0] err_addr;
  logic        err_is_wr;
  logic [15:0] err_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int b_seen = 0;
  int r_seen = 0;

  always #5 aclk = ~aclk;

  axil_default_slave dut (
    .aclk      (aclk),
    .areset    (areset),
    .s_awaddr  (s_awaddr),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_bresp   (s_bresp),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .s_araddr  (s_araddr),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready)
`ifdef AXIL_DECERR_LOG_EN
    ,
    .err_addr  (err_addr),
    .err_is_wr (err_is_wr),
    .err_cnt   (err_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".awready"}, 64'(s_awready), 64'd1);
    chk({tag, ".wready"},  64'(s_wready),  64'd1);
    chk({tag, ".arready"}, 64'(s_arready), 64'd1);
    chk({tag, ".bvalid"},  64'(s_bvalid),  64'd0);
    chk({tag, ".rvalid"},  64'(s_rvalid),  64'd0);
    chk({tag, ".bresp"},   64'(s_bresp),   64'd0);
    chk({tag, ".rresp"},   64'(s_rresp),   64'd0);
    chk({tag, ".rdata"},   64'(s_rdata),   64'd0);
  endtask

  initial begin
    areset = 1'b1;
    s_awaddr = '0; s_awvalid = 1'b0;
    s_wdata = 32'h1234_5678; s_wstrb = 4'h0; s_wvalid = 1'b0;
    s_bready = 1'b0;
    s_araddr = '0; s_arvalid = 1'b0;
    s_rready = 1'b0;
    tick(); tick();
    areset = 1'b0;

    // reset state
    chk_idle("reset");
`ifdef AXIL_DECERR_LOG_EN
    chk("reset.err_cnt", 64'(err_cnt), 64'd0);
    chk("reset.err_addr", 64'(err_addr), 64'd0);
`endif

    // 1: AW and W together, bready high
    s_awaddr = 32'h0100_0000; s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    chk("t1.bvalid", 64'(s_bvalid), 64'd1);
    chk("t1.bresp", 64'(s_bresp), 64'd3);
    chk("t1.awready", 64'(s_awready), 64'd0);
    chk("t1.wready", 64'(s_wready), 64'd0);
    tick();
    chk("t1.bvalid_done", 64'(s_bvalid), 64'd0);
    chk("t1.awready_back", 64'(s_awready), 64'd1);

    // 2: W first, AW three cycles later, bready stalled
    s_bready = 1'b0;
    s_wvalid = 1'b1;
    tick();
    s_wvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("t2.wready_wait", 64'(s_wready), 64'd0);
      chk("t2.awready_wait", 64'(s_awready), 64'd1);
      chk("t2.bvalid_wait", 64'(s_bvalid), 64'd0);
      tick();
    end
    chk("t2.wready_wait", 64'(s_wready), 64'd0);
    s_awaddr = 32'h7000_0040; s_awvalid = 1'b1;
    tick();
    s_awvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t2.bvalid_hold", 64'(s_bvalid), 64'd1);
      chk("t2.bresp_hold", 64'(s_bresp), 64'd3);
      chk("t2.awready_hold", 64'(s_awready), 64'd0);
      tick();
    end
    s_bready = 1'b1;
    chk("t2.bvalid_before_ready", 64'(s_bvalid), 64'd1);
    tick();
    chk("t2.bvalid_done", 64'(s_bvalid), 64'd0);
    chk("t2.bresp_done", 64'(s_bresp), 64'd0);

    // 3: read with one stalled cycle before rready
    s_araddr = 32'h5F00_0010; s_arvalid = 1'b1; s_rready = 1'b0;
    chk("t3.arready_pre", 64'(s_arready), 64'd1);
    tick();
    s_arvalid = 1'b0;
    chk("t3.rvalid", 64'(s_rvalid), 64'd1);
    chk("t3.rdata", 64'(s_rdata), 64'hDEAD_BEEF);
    chk("t3.rresp", 64'(s_rresp), 64'd3);
    chk("t3.arready_busy", 64'(s_arready), 64'd0);
    tick();
    chk("t3.rdata_hold", 64'(s_rdata), 64'hDEAD_BEEF);
    chk("t3.arready_busy2", 64'(s_arready), 64'd0);
    s_rready = 1'b1;
    tick();
    chk("t3.rvalid_done", 64'(s_rvalid), 64'd0);
    chk("t3.rdata_done", 64'(s_rdata), 64'd0);
    chk("t3.rresp_done", 64'(s_rresp), 64'd0);
    chk("t3.arready_back", 64'(s_arready), 64'd1);

    // 4: ten back-to-back AW+W+AR pairs, valids held high throughout
    s_bready = 1'b1; s_rready = 1'b1;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    s_awaddr = 32'h9000_0000; s_araddr = 32'h9100_0000;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (s_bvalid === 1'b1 && s_bresp === 2'b11) b_seen++;
      if (s_rvalid === 1'b1 && s_rresp === 2'b11 && s_rdata === 32'hDEAD_BEEF) r_seen++;
      chk("t4.readys_busy", 64'({s_awready, s_wready, s_arready}), 64'd0);
      tick();
      chk("t4.bubble", 64'({s_bvalid, s_rvalid}), 64'd0);
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    chk("t4.b_count", 64'(b_seen), 64'd10);
    chk("t4.r_count", 64'(r_seen), 64'd10);

    // 5: reset while both responses are pending
    s_bready = 1'b0; s_rready = 1'b0;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    chk("t5.pending", 64'({s_bvalid, s_rvalid}), 64'd3);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    chk_idle("t5.after_reset");
    s_bready = 1'b1; s_rready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5.no_stale", 64'({s_bvalid, s_rvalid}), 64'd0);
    end

`ifdef AXIL_DECERR_LOG_EN
    // 6: log records the most recent decode error
    chk("t6.cnt_reset", 64'(err_cnt), 64'd0);
    s_araddr = 32'h3100_0004; s_arvalid = 1'b1;
    tick();
    s_arvalid = 1'b0;
    chk("t6.ar_addr", 64'(err_addr), 64'h3100_0004);
    chk("t6.ar_is_wr", 64'(err_is_wr), 64'd0);
    chk("t6.ar_cnt", 64'(err_cnt), 64'd1);
    tick();
    s_awaddr = 32'hA200_0008; s_awvalid = 1'b1;
    tick();
    s_awvalid = 1'b0;
    chk("t6.aw_addr", 64'(err_addr), 64'hA200_0008);
    chk("t6.aw_is_wr", 64'(err_is_wr), 64'd1);
    chk("t6.aw_cnt", 64'(err_cnt), 64'd2);
    s_wvalid = 1'b1;
    tick();
    s_wvalid = 1'b0;
    chk("t6.bvalid", 64'(s_bvalid), 64'd1);
    tick();
    // same-cycle AW and AR: AW wins the address, count steps by two
    s_awaddr = 32'hB000_0000; s_araddr = 32'hC000_0000;
    s_awvalid = 1'b1; s_arvalid = 1'b1;
    tick();
    s_awvalid = 1'b0; s_arvalid = 1'b0;
    chk("t6.both_addr", 64'(err_addr), 64'hB000_0000);
    chk("t6.both_is_wr", 64'(err_is_wr), 64'd1);
    chk("t6.both_cnt", 64'(err_cnt), 64'd4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
